// File: rtl/loader_pkg.sv
// Shared constants and state type for the serial program loader.
package loader_pkg;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int BITCNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Host-side serial input and instruction-memory write port of the loader.
interface program_loader_if #(
    parameter int ADDR_W = loader_pkg::ADDR_W,
    parameter int DATA_W = loader_pkg::DATA_W
);

    logic              load_start;
    logic              load_abort;
    logic              ser_in;
    logic              ser_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output load_start, load_abort, ser_in, ser_valid,
        input  wr_en, wr_addr, wr_data, cpu_hold, busy, done, overrun
    );

    modport slave (
        input  load_start, load_abort, ser_in, ser_valid,
        output wr_en, wr_addr, wr_data, cpu_hold, busy, done, overrun
    );

endinterface

// File: rtl/loader_shift_reg.sv
// Serial-to-parallel word assembler with bit counter.
module loader_shift_reg #(
    parameter int DATA_W   = loader_pkg::DATA_W,
    parameter int BITCNT_W = loader_pkg::BITCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clr,
    input  logic              ser_in,
    output logic [DATA_W-1:0] word,
    output logic              full
);

    // Only the first DATA_W-1 bits are stored; the last bit is taken straight
    // from ser_in so the complete word is available on the edge that samples it.
    logic [DATA_W-2:0]   sreg;
    logic [BITCNT_W-1:0] bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            sreg    <= {sreg[DATA_W-3:0], ser_in};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign word = {sreg, ser_in};
    assign full = shift_en && (bit_cnt == BITCNT_W'(DATA_W - 1));

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: assembles instruction words, writes them to instruction
// memory and keeps the CPU in reset until the whole program is loaded.
module program_loader #(
    parameter int DEPTH  = loader_pkg::DEPTH,
    parameter int ADDR_W = loader_pkg::ADDR_W,
    parameter int DATA_W = loader_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  lif
);

    import loader_pkg::*;

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic              word_full;
    logic              shift_en;
    logic              clr;

    // Abort must also freeze the assembler in the cycle it arrives.
    always_comb begin
        shift_en = (state == SHIFT) && lif.ser_valid && !lif.load_abort;
        clr      = ((state == IDLE) && lif.load_start) ||
                   ((state == WRITE) && !lif.load_abort);
    end

    loader_shift_reg #(
        .DATA_W   (DATA_W),
        .BITCNT_W (BITCNT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (clr),
        .ser_in   (lif.ser_in),
        .word     (word),
        .full     (word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            lif.wr_en    <= 1'b0;
            lif.wr_addr  <= '0;
            lif.wr_data  <= '0;
            lif.cpu_hold <= 1'b0;
            lif.busy     <= 1'b0;
            lif.done     <= 1'b0;
            lif.overrun  <= 1'b0;
        end else begin
            lif.wr_en <= 1'b0;
            lif.done  <= 1'b0;
            if ((state != IDLE) && lif.load_abort) begin
                state        <= IDLE;
                lif.cpu_hold <= 1'b0;
                lif.busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (lif.load_start) begin
                            state        <= SHIFT;
                            addr         <= '0;
                            lif.overrun  <= 1'b0;
                            lif.cpu_hold <= 1'b1;
                            lif.busy     <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (word_full) begin
                            state       <= WRITE;
                            lif.wr_en   <= 1'b1;
                            lif.wr_addr <= addr;
                            lif.wr_data <= word;
                        end
                    end
                    WRITE: begin
                        if (lif.ser_valid) begin
                            lif.overrun <= 1'b1;
                        end
                        if (addr == ADDR_W'(DEPTH - 1)) begin
                            state        <= DONE;
                            lif.done     <= 1'b1;
                            lif.cpu_hold <= 1'b0;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= SHIFT;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        lif.busy <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader against a bit-counting reference model.
module tb_program_loader;

    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst;

    program_loader_if lif ();

    program_loader dut (
        .clk (clk),
        .rst (rst),
        .lif (lif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int writes_seen;
    int dones_seen;

    logic [DATA_W-1:0] prog   [DEPTH];
    logic [DATA_W-1:0] prog2  [DEPTH];
    logic [DATA_W-1:0] tb_mem [DEPTH];

    // Reference model: session flag, collected bit count/value and word index.
    logic              m_in_session;
    logic              m_hold;
    logic              m_ovr;
    logic              m_write_now;
    logic              m_done_now;
    int                m_nbits;
    int                m_acc;
    int                m_idx;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_session = 1'b0;
        m_hold       = 1'b0;
        m_ovr        = 1'b0;
        m_write_now  = 1'b0;
        m_done_now   = 1'b0;
        m_nbits      = 0;
        m_acc        = 0;
        m_idx        = 0;
    endtask

    task automatic model_edge(input logic s, input logic a, input logic v, input logic b);
        if (m_in_session && a) begin
            m_in_session = 1'b0;
            m_hold       = 1'b0;
            m_write_now  = 1'b0;
            m_done_now   = 1'b0;
        end else if (!m_in_session) begin
            if (s) begin
                m_in_session = 1'b1;
                m_hold       = 1'b1;
                m_ovr        = 1'b0;
                m_idx        = 0;
                m_nbits      = 0;
                m_acc        = 0;
            end
        end else if (m_done_now) begin
            m_done_now   = 1'b0;
            m_in_session = 1'b0;
        end else if (m_write_now) begin
            m_write_now = 1'b0;
            if (v) m_ovr = 1'b1;
            if (m_idx == DEPTH - 1) begin
                m_done_now = 1'b1;
                m_hold     = 1'b0;
            end else begin
                m_idx++;
            end
        end else if (v) begin
            m_acc = (m_acc * 2 + int'(b)) % 256;
            m_nbits++;
            if (m_nbits == DATA_W) begin
                m_write_now = 1'b1;
                exp_addr    = ADDR_W'(m_idx);
                exp_data    = DATA_W'(m_acc);
                m_nbits     = 0;
                m_acc       = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic v, input logic b);
        lif.load_start = s;
        lif.load_abort = a;
        lif.ser_valid  = v;
        lif.ser_in     = b;
        @(posedge clk);
        model_edge(s, a, v, b);
        @(negedge clk);
        checkOutput("ctrl", {27'd0, lif.wr_en, lif.cpu_hold, lif.busy, lif.done, lif.overrun},
                    {27'd0, m_write_now, m_hold, m_in_session, m_done_now, m_ovr});
        if (m_write_now)
            checkOutput("wr", {20'd0, lif.wr_addr, lif.wr_data}, {20'd0, exp_addr, exp_data});
        if (lif.wr_en === 1'b1) begin
            tb_mem[lif.wr_addr] = lif.wr_data;
            writes_seen++;
        end
        if (lif.done === 1'b1) dones_seen++;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input int gap_max, input logic ovr);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom));
            applyStimulus(1'b0, 1'b0, 1'b1, w[i]);
        end
        applyStimulus(1'b0, 1'b0, ovr, 1'($urandom));
    endtask

    initial begin
        prog = '{8'hAB, 8'hDE, 8'h3C, 8'h51, 8'h9F, 8'h02, 8'hE7, 8'h70,
                 8'h14, 8'hC6, 8'h3B, 8'hFF, 8'h00, 8'h6D, 8'hA5, 8'h88};
        for (int i = 0; i < DEPTH; i++) prog2[i] = DATA_W'($urandom);
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;

        rst            = 1'b1;
        lif.load_start = 1'b0;
        lif.load_abort = 1'b0;
        lif.ser_valid  = 1'b0;
        lif.ser_in     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("rst_state", {15'd0, lif.wr_en, lif.cpu_hold, lif.busy, lif.done, lif.overrun,
                                  lif.wr_addr, lif.wr_data}, 32'd0);
        rst = 1'b0;

        $display("[TB] full load with first word back-to-back");
        writes_seen = 0;
        dones_seen  = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(prog[0], 0, 1'b0);
        for (int i = 1; i < DEPTH; i++) send_word(prog[i], 3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) checkOutput("mem1", 32'(tb_mem[i]), 32'(prog[i]));
        checkOutput("writes1", writes_seen, DEPTH);
        checkOutput("dones1", dones_seen, 1);

        $display("[TB] overrun, redundant start, abort");
        writes_seen = 0;
        dones_seen  = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 0, 1'b1);
        send_word(8'hC3, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h96, 2, 1'b0);
        send_word(8'h0F, 2, 1'b0);
        send_word(8'hE1, 2, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom));
        checkOutput("ovr_next_word", 32'(tb_mem[1]), 32'h0000_00C3);
        checkOutput("addr_continue", 32'(tb_mem[2]), 32'h0000_0096);
        checkOutput("abort_writes", writes_seen, 5);
        checkOutput("abort_dones", dones_seen, 0);

        $display("[TB] start with abort in idle, then async reset mid-word");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h11, 1, 1'b1);
        send_word(8'h22, 1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom));
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst", {15'd0, lif.wr_en, lif.cpu_hold, lif.busy, lif.done, lif.overrun,
                                  lif.wr_addr, lif.wr_data}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] fresh randomized load after reset");
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
        writes_seen = 0;
        dones_seen  = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            send_word(prog2[i], 3, ($urandom_range(3, 0) == 0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) checkOutput("mem2", 32'(tb_mem[i]), 32'(prog2[i]));
        checkOutput("writes2", writes_seen, DEPTH);
        checkOutput("dones2", dones_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Serial boot loader that sits directly upstream of the processor's instruction memory. It receives a program bit-serially, assembles 8-bit instruction words, and issues one write per word into a writable 16-entry instruction memory. While loading, it holds the CPU in reset. When all 16 words are written, it releases the CPU so execution starts at address 0.

## Interface

Parameters:
- `DEPTH`, 16, number of instruction words loaded per session.
- `ADDR_W`, 4, instruction address width; must satisfy 2^ADDR_W = DEPTH.
- `DATA_W`, 8, instruction width; also the number of serial bits per word.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `load_start`  in  1  one-cycle request to begin a load session.
- `load_abort`  in  1  abandons the current session.
- `ser_in`  in  1  serial data bit, MSB of each word first.
- `ser_valid`  in  1  qualifies `ser_in` for the current cycle.
- `wr_en`  out  1  instruction-memory write strobe, one cycle long.
- `wr_addr`  out  ADDR_W  instruction-memory write address.
- `wr_data`  out  DATA_W  instruction-memory write data.
- `cpu_hold`  out  1  held high while loading; ORed into the processor's `rst`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a session completes.
- `overrun`  out  1  sticky flag: a serial bit was dropped.

## Operation

- **States:** IDLE, SHIFT, WRITE, DONE. Encoding is two bits.
- **IDLE:**
  - `load_start`=1 moves to SHIFT.
  - On that transition, clear the word address, the bit count and `overrun`, and set `cpu_hold`=1.
- **SHIFT:**
  - Each cycle with `ser_valid`=1, the shift register takes `{sreg[DATA_W-2:0], ser_in}` and the bit count increments.
  - Cycles with `ser_valid`=0 change nothing.
  - The edge that samples the 8th bit moves to WRITE.
- **WRITE:**
  - `wr_en`=1 for exactly one cycle, with `wr_data` set to the assembled word and `wr_addr` set to the current address.
  - If the address is DEPTH-1, move to DONE.
  - Otherwise increment the address, clear the bit count and return to SHIFT.
  - A `ser_valid`=1 in this cycle is dropped and sets `overrun`.
- **DONE:**
  - `done`=1 for one cycle and `cpu_hold` drops to 0, then move to IDLE.
- **Address:** `wr_addr` never wraps within a session. A new session restarts at 0.
- **`load_start` while `busy`:** ignored.
- **`load_abort`** (any state other than IDLE):
  - Next state is IDLE and `cpu_hold`=0.
  - No `done` pulse and no `wr_en`.
  - Words already written stay in memory.
  - `load_abort` has priority over every other input in the same cycle.
- **`load_abort` and `load_start` together in IDLE:** `load_start` wins, because abort has no effect in IDLE.
- **`overrun`:** stays set through DONE. It clears only on the next accepted `load_start` or on `rst`.

## Timing

- **Reset values:**
  - State = IDLE.
  - `wr_en`, `cpu_hold`, `busy`, `done` and `overrun` are all 0.
  - `wr_addr` = 0 and `wr_data` = 0.
- **Reset mid-session:** same values as above; the session is lost.
- **Registered outputs:** all outputs are registered. No combinational path from any input to any output.
- **Start:** `load_start` sampled at edge E gives `busy`=`cpu_hold`=1 from edge E.
- **Write:** the 8th `ser_valid` bit sampled at edge N gives `wr_en`=1 in the cycle after edge N, i.e. between edges N and N+1.
- **Next word:** the first bit of the next word may be sampled at edge N+2 at the earliest.
- **Minimum session length:** 1 start cycle + DEPTH × (DATA_W + 1) + 1 DONE cycle, which is 146 cycles for the defaults.
- **Hand-off to the processor:** `cpu_hold` falls on the same edge at which `done` rises, so the processor fetches address 0 on the following edge.

## Structure

- **Shared package `loader_pkg`:**
  - `DEPTH`, `ADDR_W` and `DATA_W` constants.
  - State enum `loader_state_t` (IDLE, SHIFT, WRITE, DONE).
  - `BITCNT_W` = clog2(DATA_W)+1.
- **Sub-module `loader_shift_reg`:**
  - Contains the shift register and the bit counter.
  - Inputs: `clk`, `rst`, `shift_en`, `clr`, `ser_in`.
  - Outputs: `word`, `full`.
- **FSM:** the FSM, address counter and output registers stay in `program_loader`.

## Test plan

- **Single word:** after reset, pulse `load_start`, then send bits 1,0,1,0,1,0,1,1 on consecutive cycles → `wr_en` pulse with `wr_addr`=0 and `wr_data`=0xAB, and `busy`=`cpu_hold`=1.
- **Full load:** send the 16 words 0xAB, 0xDE, 0x3C, … , 0x88 with random `ser_valid` gaps → 16 `wr_en` pulses at addresses 0–15 with matching data, then `done` for one cycle and `cpu_hold` falling on the same edge.
- **Overrun:** assert `ser_valid` during a WRITE cycle → that bit is dropped and `overrun`=1; the following word still assembles correctly from the subsequent bits, and `overrun` clears on the next `load_start`.
- **Abort:** assert `load_abort` after 5 words plus 3 bits → IDLE next cycle, `cpu_hold`=0, no further `wr_en`, no `done`.
- **Redundant start:** pulse `load_start` mid-session → no restart, and the address sequence continues.
- **Reset mid-session:** assert `rst` asynchronously during SHIFT → all outputs 0 immediately; a fresh load afterwards writes from address 0.
